// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, register-address type and zero-register constant for the
// register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned RfAddrWidth = 3;
  localparam int unsigned RfDataWidth = 16;

  typedef logic [RfAddrWidth-1:0] reg_addr_t;

  // Writes to this register are accepted but never enabled on a port.
  localparam reg_addr_t ZeroReg = '0;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin selection of up to two write requesters whose
// destination addresses differ.
module rr_pick2
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = RfAddrWidth,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] address,
  input  logic [IW-1:0]      ptr,
  output logic               grant0,
  output logic [IW-1:0]      index0,
  output logic               grant1,
  output logic [IW-1:0]      index1,
  output logic               held
);

  int unsigned   idx;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr_k;

  always_comb begin
    grant0 = 1'b0;
    index0 = '0;
    grant1 = 1'b0;
    index1 = '0;
    held   = 1'b0;
    idx    = 0;
    addr0  = '0;
    addr_k = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx    = (32'(ptr) + k) % NREQ;
      addr_k = address[idx*AW +: AW];
      if (valid[idx]) begin
        if (!grant0) begin
          grant0 = 1'b1;
          index0 = IW'(idx);
          addr0  = addr_k;
        end else if (!grant1) begin
          // Same-address requesters ahead of the port-1 pick are flagged so
          // the pointer can stop just after port 0 and serve them next.
          if (addr_k != addr0) begin
            grant1 = 1'b1;
            index1 = IW'(idx);
          end else begin
            held = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port register-file write arbiter with round-robin fairness.
// Optional macro RF_WR_PENDING_EN adds the per-register pending output.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = RfAddrWidth,
  parameter int unsigned DW   = RfDataWidth
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_address,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      data_write0_address,
  output logic [AW-1:0]      data_write1_address,
  output logic [DW-1:0]      data_write0,
  output logic [DW-1:0]      data_write1,
  output logic               reg_write_enable0,
  output logic               reg_write_enable1
`ifdef RF_WR_PENDING_EN
  ,
  output logic [2**AW-1:0]   pending
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          grant0, grant1, held;
  logic [IW-1:0] index0, index1;
  logic [IW-1:0] rr_ptr, rr_ptr_next, last_index;
  logic [AW-1:0] sel_addr0, sel_addr1;
  logic [DW-1:0] sel_data0, sel_data1;

  rr_pick2 #(
    .NREQ (NREQ),
    .AW   (AW),
    .IW   (IW)
  ) u_pick (
    .valid   (req_valid),
    .address (req_address),
    .ptr     (rr_ptr),
    .grant0  (grant0),
    .index0  (index0),
    .grant1  (grant1),
    .index1  (index1),
    .held    (held)
  );

  always_comb begin
    req_ready = '0;
    if (!reset) begin
      if (grant0) req_ready[index0] = 1'b1;
      if (grant1) req_ready[index1] = 1'b1;
    end
  end

  assign sel_addr0 = req_address[32'(index0)*AW +: AW];
  assign sel_addr1 = req_address[32'(index1)*AW +: AW];
  assign sel_data0 = req_data[32'(index0)*DW +: DW];
  assign sel_data1 = req_data[32'(index1)*DW +: DW];

  // A held requester restarts the scan right after port 0 so it cannot starve.
  assign last_index  = (grant1 && !held) ? index1 : index0;
  assign rr_ptr_next = IW'((32'(last_index) + 1) % NREQ);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr              <= '0;
      reg_write_enable0   <= 1'b0;
      reg_write_enable1   <= 1'b0;
      data_write0_address <= '0;
      data_write1_address <= '0;
      data_write0         <= '0;
      data_write1         <= '0;
    end else begin
      reg_write_enable0 <= grant0 && (sel_addr0 != AW'(ZeroReg));
      reg_write_enable1 <= grant1 && (sel_addr1 != AW'(ZeroReg));
      if (grant0) begin
        data_write0_address <= sel_addr0;
        data_write0         <= sel_data0;
        rr_ptr              <= rr_ptr_next;
      end
      if (grant1) begin
        data_write1_address <= sel_addr1;
        data_write1         <= sel_data1;
      end
    end
  end

`ifdef RF_WR_PENDING_EN
  always_comb begin
    pending = '0;
    if (reg_write_enable0) pending[data_write0_address] = 1'b1;
    if (reg_write_enable1) pending[data_write1_address] = 1'b1;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NREQ=4, AW=3, DW=16).
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [11:0] req_address;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [2:0]  data_write0_address, data_write1_address;
  logic [15:0] data_write0, data_write1;
  logic        reg_write_enable0, reg_write_enable1;
`ifdef RF_WR_PENDING_EN
  logic [7:0]  pending;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(
    .NREQ (4),
    .AW   (3),
    .DW   (16)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_address         (req_address),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .data_write0_address (data_write0_address),
    .data_write1_address (data_write1_address),
    .data_write0         (data_write0),
    .data_write1         (data_write1),
    .reg_write_enable0   (reg_write_enable0),
    .reg_write_enable1   (reg_write_enable1)
`ifdef RF_WR_PENDING_EN
    ,
    .pending             (pending)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] a, input logic [15:0] d);
    req_valid[n]          = v;
    req_address[n*3 +: 3] = a;
    req_data[n*16 +: 16]  = d;
  endtask

  task automatic clear_reqs();
    req_valid   = '0;
    req_address = '0;
    req_data    = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    set_req(0, 1'b1, 3'd3, 16'h1234);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_en0", 32'(reg_write_enable0), 32'h0);
    check("rst_en1", 32'(reg_write_enable1), 32'h0);
    check("rst_addr0", 32'(data_write0_address), 32'h0);
    check("rst_data1", 32'(data_write1), 32'h0);
    tick();
    reset = 1'b0;
    clear_reqs();

    // Single request lands on port 0 one cycle later.
    set_req(0, 1'b1, 3'd3, 16'h1234);
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    check("single_en0", 32'(reg_write_enable0), 32'h1);
    check("single_addr0", 32'(data_write0_address), 32'h3);
    check("single_data0", 32'(data_write0), 32'h1234);
    check("single_en1", 32'(reg_write_enable1), 32'h0);

    // Same address: second requester waits one cycle.
    do_reset();
    set_req(0, 1'b1, 3'd1, 16'haaaa);
    set_req(1, 1'b1, 3'd1, 16'hbbbb);
    #1;
    check("same_ready0", 32'(req_ready), 32'h1);
    tick();
    check("same_en0", 32'(reg_write_enable0), 32'h1);
    check("same_data0", 32'(data_write0), 32'haaaa);
    check("same_en1", 32'(reg_write_enable1), 32'h0);
    set_req(0, 1'b0, 3'd0, 16'h0);
    #1;
    check("same_ready1", 32'(req_ready), 32'h2);
    tick();
    check("same_en0_b", 32'(reg_write_enable0), 32'h1);
    check("same_data0_b", 32'(data_write0), 32'hbbbb);

    // Four distinct addresses: {0,1} then {2,3}, pointer back to 0.
    do_reset();
    set_req(0, 1'b1, 3'd1, 16'h0010);
    set_req(1, 1'b1, 3'd2, 16'h0020);
    set_req(2, 1'b1, 3'd3, 16'h0030);
    set_req(3, 1'b1, 3'd4, 16'h0040);
    #1;
    check("rr_ready_a", 32'(req_ready), 32'h3);
    tick();
    check("rr_addr0_a", 32'(data_write0_address), 32'h1);
    check("rr_addr1_a", 32'(data_write1_address), 32'h2);
    check("rr_en1_a", 32'(reg_write_enable1), 32'h1);
    check("rr_ready_b", 32'(req_ready), 32'hc);
    tick();
    check("rr_addr0_b", 32'(data_write0_address), 32'h3);
    check("rr_data1_b", 32'(data_write1), 32'h0040);
    clear_reqs();
    set_req(0, 1'b1, 3'd5, 16'h0055);
    set_req(1, 1'b1, 3'd6, 16'h0066);
    set_req(3, 1'b1, 3'd7, 16'h0077);
    #1;
    check("rr_ptr0_ready", 32'(req_ready), 32'h3);
    tick();
    check("p56_addr0", 32'(data_write0_address), 32'h5);
    check("p56_addr1", 32'(data_write1_address), 32'h6);
`ifdef RF_WR_PENDING_EN
    check("pending_56", 32'(pending), 32'h60);
`endif
    clear_reqs();
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("idle_en0", 32'(reg_write_enable0), 32'h0);
    check("idle_en1", 32'(reg_write_enable1), 32'h0);
    check("idle_hold_addr0", 32'(data_write0_address), 32'h5);
    check("idle_hold_data0", 32'(data_write0), 32'h0055);
`ifdef RF_WR_PENDING_EN
    check("pending_idle", 32'(pending), 32'h0);
`endif

    // Address 0 is granted but never enabled.
    set_req(2, 1'b1, 3'd0, 16'hffff);
    #1;
    check("zero_ready", 32'(req_ready), 32'h4);
    tick();
    check("zero_en0", 32'(reg_write_enable0), 32'h0);
    check("zero_en1", 32'(reg_write_enable1), 32'h0);
    clear_reqs();

    // Held requester is served next even though a later one took port 1.
    do_reset();
    set_req(0, 1'b1, 3'd1, 16'h0101);
    set_req(1, 1'b1, 3'd1, 16'h0202);
    set_req(2, 1'b1, 3'd2, 16'h0303);
    #1;
    check("held_ready_a", 32'(req_ready), 32'h5);
    tick();
    check("held_addr1", 32'(data_write1_address), 32'h2);
    set_req(2, 1'b0, 3'd0, 16'h0);
    set_req(0, 1'b1, 3'd1, 16'h0404);
    #1;
    check("held_ready_b", 32'(req_ready), 32'h2);
    tick();
    check("held_data0", 32'(data_write0), 32'h0202);
    clear_reqs();

    // Reset during a grant: asynchronous clear, no write after release.
    do_reset();
    set_req(0, 1'b1, 3'd2, 16'h2222);
    #1;
    tick();
    check("pre_rst_en0", 32'(reg_write_enable0), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_en0", 32'(reg_write_enable0), 32'h0);
    check("async_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("in_rst_en0", 32'(reg_write_enable0), 32'h0);
    clear_reqs();
    reset = 1'b0;
    tick();
    check("post_rst_en0", 32'(reg_write_enable0), 32'h0);
    check("post_rst_en1", 32'(reg_write_enable1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..4).
REQ-002 Parameter AW, default 3, register address width; DW, default 16, data width.
REQ-003 The block SHALL have a single clock; reset is asynchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester write request valid.
REQ-007 req_address  in  NREQ*AW  per-requester destination register address.
REQ-008 req_data  in  NREQ*DW  per-requester write data.
REQ-009 req_ready  out  NREQ  combinational grant; a transfer occurs when valid and ready are both high.
REQ-010 data_write0_address, data_write1_address  out  AW each  registered write-port addresses.
REQ-011 data_write0, data_write1  out  DW each  registered write-port data.
REQ-012 reg_write_enable0, reg_write_enable1  out  1 each  registered write-port enables.

Function
REQ-013 Arbitration SHALL be round-robin: requesters are scanned starting at rr_ptr, wrapping modulo NREQ.
REQ-014 The first valid requester in scan order SHALL be granted port 0.
REQ-015 The next valid requester in scan order whose address differs from the port-0 address SHALL be granted port 1.
REQ-016 A valid requester with the same address as the port-0 grant SHALL be held (req_ready low) and SHALL NOT be skipped permanently.
REQ-017 At most two requesters SHALL be granted per cycle; all others see req_ready low.
REQ-018 req_ready SHALL NOT depend on req_data.
REQ-019 Granted address/data SHALL appear on the write-port outputs one cycle after the grant, with the matching enable high for exactly that cycle.
REQ-020 A port with no grant SHALL drive its enable low the next cycle; address/data hold their previous value.
REQ-021 A request to address 0 SHALL be granted and consume its port slot, but its enable SHALL be driven low.
REQ-022 rr_ptr SHALL advance to (last granted index + 1) mod NREQ; with no grant it SHALL hold.
REQ-023 Port 0 and port 1 SHALL never be enabled with equal addresses in the same cycle.
REQ-024 A requester with req_valid high and req_ready low SHALL be granted within NREQ cycles.

Reset
REQ-025 On reset assertion, rr_ptr SHALL become 0, both enables 0, both addresses 0, both data 0, immediately and asynchronously.
REQ-026 During reset, req_ready SHALL be all zero; grants in the reset cycle are discarded.
REQ-027 A grant issued in the cycle reset asserts SHALL NOT produce a write enable after reset deasserts.

Configuration
REQ-028 Macro RF_WR_PENDING_EN, when defined, SHALL add output pending  out  2**AW, bit n high in the cycle when a write to register n is on either enabled port.
REQ-029 With RF_WR_PENDING_EN undefined, the pending port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold AW/DW defaults, the register-address typedef and the zero-register constant.
REQ-031 One sub-module, rr_pick2, SHALL implement the combinational round-robin two-grant selection; the top holds rr_ptr and the output registers.

Verification
REQ-032 Reset, then req0 valid, addr 3, data 16'h1234 -> req_ready = 0001; next cycle enable0=1, addr0=3, data0=16'h1234, enable1=0.
REQ-033 rr_ptr=0; req0 (addr 1) and req1 (addr 1) valid -> only req0 granted; req1 granted next cycle on port 0.
REQ-034 All four valid with distinct addresses 1,2,3,4 held for 2 cycles -> grants {0,1}, then {2,3}; rr_ptr ends at 0.
REQ-035 req2 valid, addr 0, data 16'hFFFF -> req_ready[2]=1; next cycle both enables 0.
REQ-036 Assert reset while req0 is granted -> enables stay 0 after release; req_ready 0 during reset.
REQ-037 With RF_WR_PENDING_EN defined: ports write regs 5 and 6 -> pending = 8'b0110_0000 that cycle, 0 the next.
